// File: rtl/bash_f_ctrl.sv
// bash-f step sequencer with its constant iterator and shared parameters.
// Define BASH_F_CTRL_STALL_CNT_EN to add the saturating RUN-stall counter output stall_cnt_o.
package bash_hash_params_pkg;
   localparam int SLEN = 64;
   localparam logic [SLEN-1:0] BASH_F_CONST = 64'hDC2BE1997FE0D8AE;
endpackage

module bash_f_c
   import bash_hash_params_pkg::*;
(
   input  logic [SLEN-1:0] c_i,
   output logic [SLEN-1:0] c_o
);
   // The constant travels byte-reversed; the LFSR step runs on the little-endian word.
   logic [SLEN-1:0] w;
   logic [SLEN-1:0] w_nxt;

   assign w     = {<<8{c_i}};
   assign w_nxt = (w >> 1) ^ (w[0] ? BASH_F_CONST : '0);
   assign c_o   = {<<8{w_nxt}};
endmodule

// state | meaning
// IDLE  | waiting for start_i
// LOAD  | one-cycle load strobe, index/constant reinitialised
// RUN   | one step per cycle unless hold_i
// DONE  | one-cycle done pulse
module bash_f_ctrl
   import bash_hash_params_pkg::*;
#(
   parameter int              ROUNDS = 24,
   parameter logic [SLEN-1:0] C_INIT = 64'hB194BAC80A08F53B
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            hold_i,
   input  logic            abort_i,
   output logic            busy_o,
   output logic            load_o,
   output logic            step_en_o,
   output logic [4:0]      step_idx_o,
   output logic [SLEN-1:0] c_o,
   output logic            last_o,
`ifdef BASH_F_CTRL_STALL_CNT_EN
   output logic [15:0]     stall_cnt_o,
`endif
   output logic            done_o
);
   if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("bash_f_ctrl: ROUNDS must be in 1..31");
   end

   localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [4:0]      idx, idx_nxt;
   logic [SLEN-1:0] c, c_nxt, c_step;
   logic            step_en;

   bash_f_c u_c (
      .c_i (c),
      .c_o (c_step)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         idx   <= '0;
         c     <= C_INIT;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         c     <= c_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      c_nxt     = c;
      step_en   = (state == RUN) && !hold_i;
      case (state)
         IDLE: if (start_i) state_nxt = LOAD;
         LOAD: begin
            idx_nxt   = '0;
            c_nxt     = C_INIT;
            state_nxt = RUN;
         end
         RUN: if (step_en) begin
            if (idx == LAST_IDX) begin
               state_nxt = DONE;
               idx_nxt   = '0;
               c_nxt     = C_INIT;
            end else begin
               idx_nxt = idx + 5'd1;
               c_nxt   = c_step;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort_i) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         c_nxt     = C_INIT;
      end
   end

   assign busy_o     = (state != IDLE);
   assign load_o     = (state == LOAD);
   assign step_en_o  = step_en;
   assign step_idx_o = idx;
   assign c_o        = c;
   assign last_o     = step_en && (idx == LAST_IDX);
   assign done_o     = (state == DONE);

`ifdef BASH_F_CTRL_STALL_CNT_EN
   logic [15:0] stall_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
      end else if (abort_i || state == LOAD) begin
         stall_cnt <= '0;
      end else if (state == RUN && hold_i && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt;
`endif
endmodule

// File: tb/tb_bash_f_ctrl.sv
// Directed self-checking bench for bash_f_ctrl: timing, constants, hold, abort, back-to-back, reset.
// Build with BASH_F_CTRL_STALL_CNT_EN defined to also cover stall_cnt_o.
module tb_bash_f_ctrl;
   localparam int ROUNDS = 24;
   localparam logic [63:0] C_INIT = 64'hB194BAC80A08F53B;

   logic        clk = 1'b0;
   logic        rst, start, hold, abort;
   logic        busy, load, step_en, last, done;
   logic [4:0]  step_idx;
   logic [63:0] c;
`ifdef BASH_F_CTRL_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   logic [63:0] tab [4];

   always #5 clk = ~clk;

   bash_f_ctrl #(.ROUNDS(ROUNDS), .C_INIT(C_INIT)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .hold_i     (hold),
      .abort_i    (abort),
      .busy_o     (busy),
      .load_o     (load),
      .step_en_o  (step_en),
      .step_idx_o (step_idx),
      .c_o        (c),
      .last_o     (last),
`ifdef BASH_F_CTRL_STALL_CNT_EN
      .stall_cnt_o(stall_cnt),
`endif
      .done_o     (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference step: byte-reverse to the LFSR word, shift with conditional feedback, reverse back.
   function automatic logic [63:0] model_next(input logic [63:0] cb);
      logic [63:0] w, r;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = cb[56-8*b +: 8];
      if (w[0]) w = (w >> 1) ^ 64'hDC2BE1997FE0D8AE;
      else      w = w >> 1;
      for (int b = 0; b < 8; b++) r[8*b +: 8] = w[56-8*b +: 8];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One permutation; hold_step/abort_step < 0 disables that event.
   task automatic run_perm(input int hold_step, input int hold_n, input int abort_step);
      int          idx, held, cyc;
      logic [63:0] mc;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      chk("load_strobe", load, 1);
      chk("busy_in_load", busy, 1);
      chk("no_step_in_load", step_en, 0);
      idx = 0; held = 0; mc = C_INIT;
      tick();
      cyc = 2;
      while (idx < ROUNDS) begin
         hold  = (idx == hold_step) && (held < hold_n);
         abort = (idx == abort_step);
         #1;
         chk("step_en", step_en, !hold);
         chk("step_idx", step_idx, idx);
         chk("c_model", c, mc);
         if (idx < 4) chk("c_table", c, tab[idx]);
         chk("last", last, !hold && idx == ROUNDS - 1);
         chk("load_in_run", load, 0);
         chk("done_in_run", done, 0);
         if (abort) begin
            tick();
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_step_en", step_en, 0);
            chk("abort_done", done, 0);
            chk("abort_idx", step_idx, 0);
            chk("abort_c", c, C_INIT);
            tick();
            chk("abort_no_late_done", done, 0);
            return;
         end
         if (hold) held++;
         else begin
            idx++;
            mc = model_next(mc);
         end
         tick();
         cyc++;
      end
      hold = 1'b0;
      chk("done_pulse", done, 1);
      chk("done_cycle", cyc, 26 + hold_n);
      chk("busy_in_done", busy, 1);
      chk("step_en_in_done", step_en, 0);
      tick();
      chk("done_single", done, 0);
      chk("busy_after", busy, 0);
   endtask

   initial begin
      int n_load;
      bit got_done;
      tab[0] = 64'hB194BAC80A08F53B;
      tab[1] = 64'hF692BD1B9C65D1C1;
      tab[2] = 64'h7BC9DE0DCEB2E860;
      tab[3] = 64'h13BC0F79FEB85FEC;
      rst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_load", load, 0);
      chk("rst_step_en", step_en, 0);
      chk("rst_done", done, 0);
      chk("rst_last", last, 0);
      chk("rst_idx", step_idx, 0);
      chk("rst_c", c, C_INIT);
`ifdef BASH_F_CTRL_STALL_CNT_EN
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
      tick(); tick();
      rst = 1'b0;
      tick();

      run_perm(-1, 0, -1);
      run_perm(5, 3, -1);
`ifdef BASH_F_CTRL_STALL_CNT_EN
      chk("stall_cnt_held", stall_cnt, 3);
`endif
      run_perm(-1, 0, 10);
      run_perm(-1, 0, -1);

      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("abort_beats_start_busy", busy, 0);
      chk("abort_beats_start_load", load, 0);

      start = 1'b1; n_load = 0; got_done = 0;
      for (int i = 0; i < 40 && !got_done; i++) begin
         tick();
         if (load) n_load++;
         if (done) got_done = 1;
      end
      chk("b2b_done_seen", got_done, 1);
      chk("b2b_one_load", n_load, 1);
      tick();
      chk("b2b_gap_busy", busy, 0);
      chk("b2b_gap_load", load, 0);
      tick();
      chk("b2b_reload", load, 1);
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("b2b_abort_idle", busy, 0);

      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("pre_rst_running", step_en, 1);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_step_en", step_en, 0);
      chk("arst_idx", step_idx, 0);
      chk("arst_c", c, C_INIT);
      chk("arst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      got_done = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done) got_done = 1;
      end
      chk("arst_no_done", got_done, 0);
      chk("arst_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bash_f_ctrl.md
Name: bash_f_ctrl

Overview:
Step sequencer for the bash-f permutation. It accepts a start request and issues a one-cycle load strobe to the external round datapath. It then drives ROUNDS step-enable cycles, each with its step index and step constant, and pulses done when the permutation completes. The constant is iterated by an internal instance of bash_f_c. Reset, stall and abort are handled so the datapath never sees a partial or duplicated step.

Parameters:
ROUNDS, 24, number of bash-f steps per permutation (legal range 1..31)
C_INIT, 64'hB194BAC80A08F53B, step-0 constant C1, in the byte order used on bash_f_c c_i/c_o
(SLEN and BASH_F_CONST come from bash_hash_params_pkg.)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  request one permutation; sampled only in IDLE
hold_i  in  1  datapath stall; suppresses step_en_o, freezes counter and constant
abort_i  in  1  synchronous abort to IDLE, highest priority after reset
busy_o  out  1  high in LOAD, RUN and DONE
load_o  out  1  one-cycle strobe: datapath captures input state
step_en_o  out  1  datapath applies one step this cycle
step_idx_o  out  5  current step index, 0..ROUNDS-1
c_o  out  SLEN  step constant for step_idx_o
last_o  out  1  step_en_o && step_idx_o==ROUNDS-1
done_o  out  1  one-cycle pulse: datapath output valid

Behaviour:
- Reset values: FSM=IDLE, busy_o=0, load_o=0, step_en_o=0, done_o=0, last_o=0, step_idx_o=0, c_o=C_INIT.
- All outputs are registered-state decodes; no combinational path from start_i to any output. Exceptions: step_en_o and last_o are gated combinationally by hold_i.
- FSM states and transitions:
  - IDLE: start_i=1 -> LOAD. Otherwise stay.
  - LOAD: load_o=1 for exactly one cycle. step_idx <= 0, c <= C_INIT. -> RUN. hold_i is ignored in LOAD.
  - RUN: step_en_o = ~hold_i.
    - On step_en_o: c <= bash_f_c(c), step_idx <= step_idx+1.
    - On step_en_o with step_idx==ROUNDS-1: -> DONE. The constant update that cycle is don't-care; it is reloaded in the next LOAD.
    - hold_i=1: no step, state, index and constant unchanged.
  - DONE: done_o=1 for one cycle -> IDLE.
- start_i in LOAD, RUN or DONE is ignored, not queued. A start asserted in the DONE cycle is lost. The next start is accepted in IDLE, one cycle later.
- Latency with no hold:
  - start_i sampled at edge k: load_o in cycle k+1.
  - Steps 0..ROUNDS-1 in cycles k+2..k+ROUNDS+1.
  - done_o in cycle k+ROUNDS+2, i.e. 26 cycles after the start edge for ROUNDS=24.
  - Each hold cycle in RUN adds exactly one cycle.
- abort_i=1 in any state: next state IDLE, no done_o, index and constant reset to 0/C_INIT. Outputs are deasserted from the next cycle.
- abort_i and start_i together in IDLE: abort wins and the FSM stays IDLE.
- Asynchronous reset mid-RUN: immediate return to reset values. No done_o is generated.
- Constant sequence: c_o at step r equals r applications of bash_f_c to C_INIT. It must match a reference model for all r < ROUNDS.
- step_idx_o width is fixed at 5 bits. ROUNDS>31 is illegal and caught by an elaboration-time assertion.

Optional Feature:
Macro BASH_F_CTRL_STALL_CNT_EN.
- Defined: adds output stall_cnt_o [15:0].
  - Counts cycles in RUN with hold_i=1.
  - Cleared to 0 in LOAD and held after DONE until the next LOAD.
  - Saturates at 16'hFFFF.
  - Reset value 0. Abort also clears it.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then start_i pulse at edge k, hold_i=0 -> load_o at k+1; step_en_o high for exactly 24 cycles, step_idx_o 0..23; last_o only at idx 23; done_o single pulse at k+26; busy_o low at k+27.
- Same run checking c_o each step against the model -> step 0 c_o=64'hB194BAC80A08F53B; steps 1..23 equal iterated bash_f_c outputs.
- hold_i=1 for 3 cycles during step 5 -> step_idx_o stays 5, c_o unchanged, step_en_o low; done_o delayed to k+29; stall_cnt_o=3 when the macro is defined.
- abort_i at step 10 -> IDLE next cycle, no done_o; a fresh start restarts at idx 0 with c_o=C_INIT.
- start_i held high continuously -> permutations complete back-to-back with one IDLE cycle between done_o and the next load_o; starts during busy are ignored.
- rst_i asserted asynchronously mid-RUN (between edges) -> all outputs return to reset values immediately; no done_o.
